fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Owns the PC and issues word-aligned requests to instruction memory over a valid/ready request channel with a valid-only response channel. Presents the fetched word plus its PC to decode through a stallable output register. Supports branch/jump redirect and discards in-flight responses made stale by a redirect.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset
PC_INC, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  fetch address (current PC)
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  response word valid
imem_rsp_data  in  32  fetched instruction word
stall  in  1  decode cannot accept; hold output register
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  redirect target
inst  out  32  instruction word to decoder
inst_pc  out  32  PC of inst
inst_valid  out  1  inst/inst_pc hold a live instruction

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, kill=0, hold buffer empty; inst=0, inst_pc=0, inst_valid=0, imem_req_valid=0.
- imem_req_valid = (state==REQ); imem_req_addr = pc. Both combinational from registers.
- At most one outstanding request.
- FSM states IDLE, REQ, WAIT, HOLD:
  - IDLE -> REQ unconditionally (first request appears the cycle after rst deasserts).
  - REQ: on imem_req_ready: req_pc<=pc, pc<=pc+PC_INC (mod 2^32), -> WAIT. Otherwise stay; pc and addr remain stable.
  - WAIT: on imem_rsp_valid:
    - if kill: drop word, kill<=0, -> REQ.
    - else if output register free (!inst_valid || !stall): inst<=data, inst_pc<=req_pc, inst_valid<=1, -> REQ.
    - else: hold buffer <= {data, req_pc}, -> HOLD.
  - HOLD: when !stall, move hold buffer into output register (inst_valid=1), -> REQ.
- Output register: if stall && inst_valid, inst/inst_pc/inst_valid are unchanged. If !stall and no new word is loaded this cycle, inst_valid<=0; inst and inst_pc keep their values.
- Latency: request accepted at cycle N, response at N+k (k>=1) -> inst_valid at N+k+1. Peak throughput is one instruction per 2 cycles.
- Redirect has priority over everything except rst, and over stall:
  - Always: pc<=redirect_pc, inst_valid<=0, hold buffer cleared.
  - IDLE/HOLD: -> REQ.
  - REQ with ready the same cycle: the old-PC request is accepted but stale: kill<=1, -> WAIT.
  - REQ without ready: stay REQ with the new address. The address change while valid is permitted only on redirect.
  - WAIT with rsp the same cycle: drop the word, kill<=0, -> REQ.
  - WAIT without rsp: kill<=1, stay WAIT.
- Back-to-back redirects: the last one wins; kill stays 1 until one response is dropped.
- imem_rsp_valid outside WAIT is ignored.
- rst asserted mid-transaction: all state cleared immediately. Memory must not deliver a response for a request issued before reset.

Test Plan:
- Reset release, ready=1, rsp 1 cycle later with data 0xA0000001, 0xA0000002 -> addrs 0x0, 0x4; inst_valid pulses carry inst_pc 0x0, 0x4; inst_valid asserts 2 cycles after each request acceptance.
- Stall held 4 cycles while inst_valid=1 and next rsp arrives -> output register unchanged, FSM in HOLD. On stall release, the held word appears next cycle and the next request follows one cycle later.
- Redirect to 0x100 while in WAIT; stale rsp 0xDEADBEEF arrives 2 cycles later -> word dropped, inst_valid stays 0, next request addr=0x100, its response emitted with inst_pc=0x100.
- Redirect coincident with request acceptance at pc=0x8 -> stale response dropped; next request addr=redirect_pc.
- imem_req_ready=0 for 3 cycles -> imem_req_valid held, addr stable at the same PC; no pc increment.
- rst pulsed mid-WAIT -> inst_valid=0 and req_valid=0 immediately; fetch restarts at RESET_PC the cycle after deassertion.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding the decoder.
// Owns the PC, issues one word-aligned request at a time to instruction memory
// (valid/ready request, valid-only response), and presents {inst, inst_pc} to
// decode through a stallable output register backed by a one-entry hold buffer.
// A redirect restarts fetch at redirect_pc and kills the in-flight response.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   imem_req_valid/addr/ready  fetch request channel (addr is the current PC)
//   imem_rsp_valid/data        fetch response channel
//   stall                      decode cannot accept; hold the output register
//   redirect_valid/pc          flush and restart fetch at redirect_pc
//   inst, inst_pc, inst_valid  instruction word, its PC, and its valid flag
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              kill_q, kill_d;
  logic              hold_valid_q, hold_valid_d;
  logic [XLEN-1:0]   hold_data_q, hold_data_d;
  logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_pc_q    <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_pc_q    <= hold_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Next-state logic: normal fetch flow first, redirect overrides last
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_pc_d    = hold_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    // Decode consumes the current word whenever it is not stalling
    if (!stall) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(PC_INC);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else if (!inst_valid_q || !stall) begin
            inst_d       = imem_rsp_data;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
            state_d      = ST_REQ;
          end else begin
            hold_valid_d = 1'b1;
            hold_data_d  = imem_rsp_data;
            hold_pc_d    = req_pc_q;
            state_d      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall && hold_valid_q) begin
          inst_d       = hold_data_q;
          inst_pc_d    = hold_pc_q;
          inst_valid_d = 1'b1;
          hold_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Redirect beats stall and normal flow; a request already in flight
    // (or accepted this cycle) is marked for discard via kill.
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = 1'b0;
      hold_valid_d = 1'b0;
      case (state_q)
        ST_REQ: begin
          if (imem_req_ready) begin
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_valid     = inst_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed sequence with exact cycle checks followed
// by randomized traffic, all checked against a transaction-level model of the
// fetch stream (expected next fetch address, one memory slot, FIFO of words
// owed to decode).
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  fetch_stage #(.RESET_PC(RESET_PC), .PC_INC(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [31:0] exp_pc;
  bit          mem_busy;
  bit          mem_stale;
  int          mem_delay;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [63:0] exp_q[$];
  logic [31:0] dir_data[$];
  int          fix_delay;
  bit          spurious_en;

  int n_tests;
  int n_fail;
  int n_consumed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Assert reset at a falling edge; outputs must clear without a clock edge.
  task automatic do_reset(input int ncyc);
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);
    check_eq("rst_req_addr", imem_req_addr, RESET_PC);
    repeat (ncyc) @(negedge clk);
    rst       = 1'b0;
    exp_pc    = RESET_PC;
    mem_busy  = 1'b0;
    mem_stale = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs at the falling edge, check registered
  // outputs against the model, advance the model, wait for the next falling edge.
  task automatic step(input bit st, input bit rdy, input bit rd, input logic [31:0] rpc);
    bit          resp;
    bit          hs;
    logic [63:0] f;
    resp           = mem_busy && (mem_delay == 0);
    imem_rsp_valid = resp || (spurious_en && !mem_busy && ($urandom_range(0, 7) == 0));
    imem_rsp_data  = resp ? mem_data : $urandom;
    stall          = st;
    imem_req_ready = rdy;
    redirect_valid = rd;
    redirect_pc    = rpc;

    if (imem_req_valid) begin
      check_eq("req_addr", imem_req_addr, exp_pc);
      check_eq("req_while_outstanding", 32'(mem_busy), 32'd0);
    end
    if (inst_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("inst_valid_unexpected", 32'(inst_valid), 32'd0);
      end else begin
        f = exp_q[0];
        check_eq("inst_pc", inst_pc, f[63:32]);
        check_eq("inst", inst, f[31:0]);
        if (!st) begin
          void'(exp_q.pop_front());
          n_consumed++;
        end
      end
    end

    hs = imem_req_valid && rdy;
    if (mem_busy) begin
      if (resp) begin
        mem_busy = 1'b0;
        if (!mem_stale && !rd) exp_q.push_back({mem_addr, mem_data});
      end else begin
        mem_delay--;
        if (rd) mem_stale = 1'b1;
      end
    end
    if (rd) exp_q.delete();
    if (hs) begin
      mem_busy  = 1'b1;
      mem_addr  = exp_pc;
      mem_stale = rd;
      mem_delay = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
      mem_data  = (dir_data.size() != 0) ? dir_data.pop_front() : $urandom;
    end
    if (rd) exp_pc = rpc;
    else if (hs) exp_pc = exp_pc + 32'd4;
    @(negedge clk);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    n_consumed  = 0;
    fix_delay   = 0;
    spurious_en = 1'b0;
    exp_pc      = RESET_PC;
    mem_busy    = 1'b0;
    mem_stale   = 1'b0;
    mem_delay   = 0;
    mem_addr    = '0;
    mem_data    = '0;
    rst         = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    @(negedge clk);
    do_reset(2);

    // Basic flow: two fetches, one-cycle memory
    check_eq("idle_no_req", 32'(imem_req_valid), 32'd0);
    dir_data.push_back(32'hA000_0001);
    dir_data.push_back(32'hA000_0002);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("first_req_addr", imem_req_addr, 32'h0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("wait_no_req", 32'(imem_req_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("lat_inst_valid0", 32'(inst_valid), 32'd1);
    check_eq("lat_inst0", inst, 32'hA000_0001);
    check_eq("second_req_addr", imem_req_addr, 32'h4);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("pulse_end", 32'(inst_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("lat_inst_valid1", 32'(inst_valid), 32'd1);
    check_eq("lat_inst_pc1", inst_pc, 32'h4);

    // Stall for 4 cycles while the next response lands in the hold buffer
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    check_eq("stall_inst_held", inst, 32'hA000_0002);
    check_eq("stall_valid_held", 32'(inst_valid), 32'd1);
    check_eq("hold_no_req", 32'(imem_req_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("hold_release_pc", inst_pc, 32'h8);
    check_eq("hold_release_req", 32'(imem_req_valid), 32'd1);
    check_eq("hold_release_addr", imem_req_addr, 32'hC);

    // Redirect during WAIT; stale word arrives two cycles later
    fix_delay = 2;
    dir_data.push_back(32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0, '0);
    fix_delay = 0;
    step(1'b0, 1'b1, 1'b1, 32'h100);
    check_eq("redir_valid_drop", 32'(inst_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("stale_dropped", 32'(inst_valid), 32'd0);
    check_eq("redir_req_addr", imem_req_addr, 32'h100);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("redir_inst_pc", inst_pc, 32'h100);

    // Redirect in REQ without ready, then redirect coincident with acceptance
    step(1'b0, 1'b0, 1'b1, 32'h8);
    check_eq("req_retarget_addr", imem_req_addr, 32'h8);
    step(1'b0, 1'b1, 1'b1, 32'h200);
    check_eq("accept_redir_wait", 32'(imem_req_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("accept_redir_drop", 32'(inst_valid), 32'd0);
    check_eq("accept_redir_addr", imem_req_addr, 32'h200);

    // Memory not ready for 3 cycles: request and address held
    repeat (3) begin
      step(1'b0, 1'b0, 1'b0, '0);
      check_eq("noready_valid", 32'(imem_req_valid), 32'd1);
      check_eq("noready_addr", imem_req_addr, 32'h200);
    end

    // Reset in the middle of WAIT
    step(1'b0, 1'b1, 1'b0, '0);
    do_reset(2);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("restart_addr", imem_req_addr, RESET_PC);
    check_eq("restart_valid", 32'(imem_req_valid), 32'd1);

    // Randomized traffic
    fix_delay   = -1;
    spurious_en = 1'b1;
    n_consumed  = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        logic [31:0] rpc;
        rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
             $urandom_range(0, 99) < 6, rpc);
      end
    end
    check_eq("random_progress", 32'(n_consumed > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
